// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_if
// Purpose  : Opcode/handshake inputs and control/status outputs of the
//            multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_control_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] Opcode;
    logic           MemReady;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           MemtoReg;
    logic           RegDst;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     ALUOp;
    logic [1:0]     PCSource;
    logic [3:0]     State;
    logic           InstrDone;
    logic           Illegal;

    // Controller side: consumes opcode/ready, drives the datapath controls.
    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, InstrDone, Illegal
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, InstrDone, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Purpose  : Moore FSM sequencing a classic multi-cycle MIPS-style datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_control #(
    parameter int           OPW      = 6,
    parameter logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000),
    parameter logic [OPW-1:0] OP_LW    = OPW'(6'b100011),
    parameter logic [OPW-1:0] OP_SW    = OPW'(6'b101011),
    parameter logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100),
    parameter logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000),
    parameter logic [OPW-1:0] OP_J     = OPW'(6'b000010),
    parameter bit           MEM_WAIT = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    multi_cycle_control_if.master   bus
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_ADDIEX = 4'd10;
    localparam logic [3:0] c_ADDIWB = 4'd11;

    logic [3:0]     r_state;
    logic [3:0]     w_nextState;
    logic [OPW-1:0] r_opcode;
    logic           w_ready;

    logic       w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite;
    logic       w_irWrite, w_memtoReg, w_regDst, w_regWrite, w_aluSrcA;
    logic [1:0] w_aluSrcB, w_aluOp, w_pcSource;
    logic       w_instrDone, w_illegal;

    assign w_ready = MEM_WAIT ? bus.MemReady : 1'b1;

    // State register; opcode captured in DECODE so later states ignore bus changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == c_DECODE) begin
                r_opcode <= bus.Opcode;
            end
        end
    end

    always_comb begin
        w_nextState = c_FETCH;
        case (r_state)
            c_FETCH:  w_nextState = w_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
                    w_nextState = c_MEMADR;
                end else if (bus.Opcode == OP_RTYPE) begin
                    w_nextState = c_EXEC;
                end else if (bus.Opcode == OP_BEQ) begin
                    w_nextState = c_BRANCH;
                end else if (bus.Opcode == OP_ADDI) begin
                    w_nextState = c_ADDIEX;
                end else if (bus.Opcode == OP_J) begin
                    w_nextState = c_JUMP;
                end else begin
                    w_nextState = c_FETCH;
                end
            end
            c_MEMADR: w_nextState = (r_opcode == OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_nextState = w_ready ? c_MEMWB : c_MEMRD;
            c_MEMWB:  w_nextState = c_FETCH;
            c_MEMWR:  w_nextState = w_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_nextState = c_RWB;
            c_RWB:    w_nextState = c_FETCH;
            c_BRANCH: w_nextState = c_FETCH;
            c_JUMP:   w_nextState = c_FETCH;
            c_ADDIEX: w_nextState = c_ADDIWB;
            c_ADDIWB: w_nextState = c_FETCH;
            default:  w_nextState = c_FETCH;
        endcase
    end

    // Outputs are all forced low while rst is high, even before the reset edge.
    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memtoReg    = 1'b0;
        w_regDst      = 1'b0;
        w_regWrite    = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_aluOp       = 2'b00;
        w_pcSource    = 2'b00;
        w_instrDone   = 1'b0;
        w_illegal     = 1'b0;
        if (!rst) begin
            case (r_state)
                c_FETCH: begin
                    w_memRead = 1'b1;
                    w_aluSrcB = 2'b01;
                    w_irWrite = w_ready;
                    w_pcWrite = w_ready;
                end
                c_DECODE: begin
                    w_aluSrcB = 2'b11;
                    w_illegal = !(bus.Opcode == OP_LW   || bus.Opcode == OP_SW  ||
                                  bus.Opcode == OP_RTYPE || bus.Opcode == OP_BEQ ||
                                  bus.Opcode == OP_ADDI || bus.Opcode == OP_J);
                end
                c_MEMADR: begin
                    w_aluSrcA = 1'b1;
                    w_aluSrcB = 2'b10;
                end
                c_MEMRD: begin
                    w_memRead = 1'b1;
                    w_iorD    = 1'b1;
                end
                c_MEMWB: begin
                    w_regWrite  = 1'b1;
                    w_memtoReg  = 1'b1;
                    w_instrDone = 1'b1;
                end
                c_MEMWR: begin
                    w_memWrite  = 1'b1;
                    w_iorD      = 1'b1;
                    w_instrDone = w_ready;
                end
                c_EXEC: begin
                    w_aluSrcA = 1'b1;
                    w_aluOp   = 2'b10;
                end
                c_RWB: begin
                    w_regWrite  = 1'b1;
                    w_regDst    = 1'b1;
                    w_instrDone = 1'b1;
                end
                c_BRANCH: begin
                    w_aluSrcA     = 1'b1;
                    w_aluOp       = 2'b01;
                    w_pcWriteCond = 1'b1;
                    w_pcSource    = 2'b01;
                    w_instrDone   = 1'b1;
                end
                c_JUMP: begin
                    w_pcWrite   = 1'b1;
                    w_pcSource  = 2'b10;
                    w_instrDone = 1'b1;
                end
                c_ADDIEX: begin
                    w_aluSrcA = 1'b1;
                    w_aluSrcB = 2'b10;
                end
                c_ADDIWB: begin
                    w_regWrite  = 1'b1;
                    w_instrDone = 1'b1;
                end
                default: begin
                    w_pcWrite = 1'b0;
                end
            endcase
        end
    end

    assign bus.PCWrite     = w_pcWrite;
    assign bus.PCWriteCond = w_pcWriteCond;
    assign bus.IorD        = w_iorD;
    assign bus.MemRead     = w_memRead;
    assign bus.MemWrite    = w_memWrite;
    assign bus.IRWrite     = w_irWrite;
    assign bus.MemtoReg    = w_memtoReg;
    assign bus.RegDst      = w_regDst;
    assign bus.RegWrite    = w_regWrite;
    assign bus.ALUSrcA     = w_aluSrcA;
    assign bus.ALUSrcB     = w_aluSrcB;
    assign bus.ALUOp       = w_aluOp;
    assign bus.PCSource    = w_pcSource;
    assign bus.InstrDone   = w_instrDone;
    assign bus.Illegal     = w_illegal;
    assign bus.State       = rst ? 4'd0 : r_state;

endmodule
`default_nettype wire

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter OPW, default 6: opcode width in bits; must be at least 6.
REQ-002 Parameter OP_RTYPE, default 6'b000000: R-type opcode.
REQ-003 Parameter OP_LW / OP_SW, defaults 6'b100011 / 6'b101011: load and store opcodes.
REQ-004 Parameter OP_BEQ / OP_ADDI / OP_J, defaults 6'b000100 / 6'b001000 / 6'b000010: branch, add-immediate and jump opcodes.
REQ-005 Parameter MEM_WAIT, default 1: 1 = fetch and memory states wait for MemReady; 0 = MemReady is ignored and treated as 1.
REQ-006 Single clock and reset: clk input 1 (rising edge); reset is synchronous and active-high; rst input 1.
REQ-007 Opcode in OPW: instruction opcode, sampled in DECODE.
REQ-008 MemReady in 1: memory transfer completes this cycle.
REQ-009 Control outputs:
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA: out 1 each.
- ALUSrcB, ALUOp, PCSource: out 2 each.
REQ-010 Status outputs: State out 4 (current state); InstrDone out 1 (instruction retires this cycle); Illegal out 1 (undecoded opcode).

Function
REQ-011 The block SHALL be a Moore FSM with a 4-bit encoded state register. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 FETCH SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00. IRWrite=1 and PCWrite=1 SHALL be asserted only while MemReady=1. The FSM SHALL stay in FETCH while MemReady=0, otherwise go to DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
- LW/SW -> MEMADR
- RTYPE -> EXEC
- BEQ -> BRANCH
- ADDI -> ADDIEX
- J -> JUMP
- any other opcode -> FETCH, with Illegal=1 for that one cycle.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD if the opcode captured in DECODE is LW, else MEMWR.
REQ-015 MEMRD SHALL assert MemRead=1, IorD=1, and hold until MemReady=1, then go to MEMWB.
REQ-016 MEMWB SHALL assert RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1, then go to FETCH.
REQ-017 MEMWR SHALL assert MemWrite=1, IorD=1, and hold until MemReady=1. On exit it SHALL assert InstrDone=1 and go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to RWB. RWB SHALL assert RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1, then go to FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1, then go to FETCH.
REQ-020 JUMP SHALL assert PCWrite=1, PCSource=10, InstrDone=1, then go to FETCH.
REQ-021 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00 and go to ADDIWB. ADDIWB SHALL assert RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1, then go to FETCH.
REQ-022 Opcode SHALL be latched into an internal OPW-bit register in DECODE. Later states SHALL use the latched value, so Opcode changes after DECODE have no effect.
REQ-023 Every output not listed for a state SHALL be 0.
REQ-024 Unused state encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-025 Instruction latency with MemReady held at 1:
- LW: 5 cycles
- SW, R-type, ADDI: 4 cycles
- BEQ, J: 3 cycles
- illegal opcode: 2 cycles.
Each wait cycle SHALL add exactly one cycle.

Reset
REQ-026 When rst=1 at a rising clk edge, State SHALL become FETCH; the latched opcode SHALL become 0.
REQ-027 While rst=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, InstrDone and Illegal SHALL be forced to 0; all other outputs SHALL be 0.
REQ-028 Reset asserted mid-instruction, including during a MemReady stall, SHALL abort the instruction with no further write enable, and resume at FETCH.

Verification
REQ-029 Opcode=000000, MemReady=1 -> States 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; InstrDone pulses once.
REQ-030 Opcode=100011, MemReady low 2 cycles in MEMRD -> States 0,1,2,3,3,3,4,0; MemtoReg=1 in state 4; 7 cycles total.
REQ-031 Opcode=101011, then Opcode changed to 000100 during MEMADR -> MEMWR still entered; MemWrite=1 and IorD=1; no RegWrite.
REQ-032 Opcode=111111 -> States 0,1,0; Illegal=1 for one cycle; no write enable asserted.
REQ-033 rst=1 during MEMWR stall -> next State=0; MemWrite=0 immediately and after release; the following fetch proceeds normally.
REQ-034 Parameter MEM_WAIT=0 with MemReady tied 0 -> BEQ sequence 0,1,8,0 completes in 3 cycles; PCWriteCond=1 and PCSource=01 in state 8.
